// File: rtl/mc_seq_pkg.sv
// Shared types and constants for the multi-cycle MIPS sequencer.
// Holds state/class enums, pc_sel codes and instruction-bit indices.
package mc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT
  } state_t;

  typedef enum logic [3:0] {
    NONE, ALU_R, ALU_I, JR, LW, SW,
    BEQ, BNE, J, JAL, ILLEGAL
  } cls_t;

  localparam logic [1:0] PCSEL_SEQ = 2'd0;
  localparam logic [1:0] PCSEL_BR  = 2'd1;
  localparam logic [1:0] PCSEL_JMP = 2'd2;
  localparam logic [1:0] PCSEL_REG = 2'd3;

  localparam int I_ALUR_HI  = 15;
  localparam int I_JR       = 16;
  localparam int I_ALUI_LO  = 17;
  localparam int I_ALUI_HI  = 21;
  localparam int I_LW       = 22;
  localparam int I_SW       = 23;
  localparam int I_BEQ      = 24;
  localparam int I_BNE      = 25;
  localparam int I_ALUI2_LO = 26;
  localparam int I_ALUI2_HI = 28;
  localparam int I_J        = 29;
  localparam int I_JAL      = 30;
  localparam int I_ILL      = 31;

endpackage

// File: rtl/mc_seq_if.sv
// Sequencer bus: decoder/ALU/memory inputs and per-phase strobes.
// master = sequencer side, slave = datapath/bench side.
interface mc_seq_if #(
  parameter int IW     = 32,
  parameter int PERF_W = 32
);
  logic              run;
  logic [IW-1:0]     i;
  logic              z;
  logic              im_ack;
  logic              dm_ack;
  logic              im_req;
  logic              ir_we;
  logic              dm_req;
  logic              dm_we;
  logic              rf_w;
  logic              pc_we;
  logic [1:0]        pc_sel;
  logic              halted;
  logic              busy;
  logic [PERF_W-1:0] perf_cyc;
  logic [PERF_W-1:0] perf_ret;

  modport master (
    input  run, i, z, im_ack, dm_ack,
    output im_req, ir_we, dm_req, dm_we,
    output rf_w, pc_we, pc_sel, halted,
    output busy, perf_cyc, perf_ret
  );

  modport slave (
    output run, i, z, im_ack, dm_ack,
    input  im_req, ir_we, dm_req, dm_we,
    input  rf_w, pc_we, pc_sel, halted,
    input  busy, perf_cyc, perf_ret
  );
endinterface

// File: rtl/mc_seq_classify.sv
// Combinational one-hot instruction vector -> instruction class.
// Ports: i_i (one-hot vector), o_cls (class; ILLEGAL if not one-hot).
module mc_seq_classify
  import mc_seq_pkg::*;
#(
  parameter int IW = 32
) (
  input  logic [IW-1:0] i_i,
  output cls_t          o_cls
);

  logic w_onehot;

  // bit 31 is reserved and always illegal
  assign w_onehot = ($countones(i_i) == 1)
                  && !i_i[I_ILL];

  always_comb begin
    o_cls = ILLEGAL;
    if (w_onehot) begin
      unique case (1'b1)
        |i_i[I_ALUR_HI:0]:
          o_cls = ALU_R;
        i_i[I_JR]:
          o_cls = JR;
        |i_i[I_ALUI_HI:I_ALUI_LO],
        |i_i[I_ALUI2_HI:I_ALUI2_LO]:
          o_cls = ALU_I;
        i_i[I_LW]:  o_cls = LW;
        i_i[I_SW]:  o_cls = SW;
        i_i[I_BEQ]: o_cls = BEQ;
        i_i[I_BNE]: o_cls = BNE;
        i_i[I_J]:   o_cls = J;
        i_i[I_JAL]: o_cls = JAL;
        default:    o_cls = ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS datapath.
// Ports: clk, rst_n, bus (mc_seq_if.master). Macro MC_SEQ_PERF_EN adds perf counters.
module mc_sequencer
  import mc_seq_pkg::*;
#(
  parameter int IW     = 32,
  parameter int PERF_W = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  mc_seq_if.master bus
);

  state_t     r_state;
  state_t     w_nxt;
  state_t     w_to_fetch;
  cls_t       r_cls;
  cls_t       w_cls;
  logic       w_im_req;
  logic       w_ir_we;
  logic       w_dm_req;
  logic       w_dm_we;
  logic       w_rf_w;
  logic       w_pc_we;
  logic [1:0] w_pc_sel;
  logic       w_busy;

  mc_seq_classify #(.IW(IW)) u_cls (
    .i_i   (bus.i),
    .o_cls (w_cls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cls   <= NONE;
    end else begin
      r_state <= w_nxt;
      if (r_state == DECODE) r_cls <= w_cls;
    end
  end

  // dropping run parks the sequencer instead of fetching
  assign w_to_fetch = bus.run ? FETCH : IDLE;

  always_comb begin
    w_nxt    = r_state;
    w_im_req = 1'b0;
    w_ir_we  = 1'b0;
    w_dm_req = 1'b0;
    w_dm_we  = 1'b0;
    w_rf_w   = 1'b0;
    w_pc_we  = 1'b0;
    w_pc_sel = PCSEL_SEQ;
    unique case (r_state)
      IDLE: if (bus.run) w_nxt = FETCH;
      FETCH: begin
        w_im_req = 1'b1;
        if (bus.im_ack) begin
          w_ir_we = 1'b1;
          w_nxt   = DECODE;
        end
      end
      DECODE:
        w_nxt = (w_cls == ILLEGAL) ? HALT : EXEC;
      EXEC: begin
        case (r_cls)
          BEQ, BNE: begin
            w_pc_we = 1'b1;
            if ((r_cls == BEQ) == bus.z)
              w_pc_sel = PCSEL_BR;
            w_nxt = w_to_fetch;
          end
          J: begin
            w_pc_we  = 1'b1;
            w_pc_sel = PCSEL_JMP;
            w_nxt    = w_to_fetch;
          end
          JR: begin
            w_pc_we  = 1'b1;
            w_pc_sel = PCSEL_REG;
            w_nxt    = w_to_fetch;
          end
          LW, SW:  w_nxt = MEM;
          default: w_nxt = WB;
        endcase
      end
      MEM: begin
        w_dm_req = 1'b1;
        w_dm_we  = (r_cls == SW);
        if (bus.dm_ack) begin
          if (r_cls == SW) begin
            w_pc_we = 1'b1;
            w_nxt   = w_to_fetch;
          end else begin
            w_nxt = WB;
          end
        end
      end
      WB: begin
        w_rf_w  = 1'b1;
        w_pc_we = 1'b1;
        if (r_cls == JAL) w_pc_sel = PCSEL_JMP;
        w_nxt = w_to_fetch;
      end
      HALT:    w_nxt = HALT;
      default: w_nxt = IDLE;
    endcase
  end

  assign w_busy = (r_state != IDLE)
               && (r_state != HALT);

  assign bus.im_req = w_im_req;
  assign bus.ir_we  = w_ir_we;
  assign bus.dm_req = w_dm_req;
  assign bus.dm_we  = w_dm_we;
  assign bus.rf_w   = w_rf_w;
  assign bus.pc_we  = w_pc_we;
  assign bus.pc_sel = w_pc_sel;
  assign bus.halted = (r_state == HALT);
  assign bus.busy   = w_busy;

`ifdef MC_SEQ_PERF_EN
  logic [PERF_W-1:0] r_perf_cyc;
  logic [PERF_W-1:0] r_perf_ret;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_cyc <= '0;
      r_perf_ret <= '0;
    end else begin
      if (w_busy)
        r_perf_cyc <= r_perf_cyc + PERF_W'(1);
      if (w_pc_we)
        r_perf_ret <= r_perf_ret + PERF_W'(1);
    end
  end

  assign bus.perf_cyc = r_perf_cyc;
  assign bus.perf_ret = r_perf_ret;
`else
  assign bus.perf_cyc = '0;
  assign bus.perf_ret = '0;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Scoreboard bench for mc_sequencer: directed and random instruction streams.
// A driver issues instructions/acks, a monitor checks each retire against a queue.
module tb_mc_sequencer;

  typedef struct {
    logic [1:0] sel;
    logic       rf;
    int         dmc;
    logic       dwe;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mc_seq_if #(.IW(32), .PERF_W(32)) bus ();

  mc_sequencer #(.IW(32), .PERF_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_iss = 0;
  int n_ret = 0;
  int cyc = 0;
  int irwe_cyc = 0;
  int dmc = 0;
  bit chk_idle = 0;

  exp_t q[$];
  logic [31:0] dq_i[$];
  logic dq_z[$];
  int dq_w[$];
  int rand_left = 0;
  bit rand_run = 0;
  bit spur = 0;
  int im_wmax = 0;
  int dm_wmax = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic bit have();
    return (dq_i.size() > 0) || (rand_left > 0);
  endfunction

  function automatic bit legal(input logic [31:0] ins);
    return ($countones(ins) == 1) && !ins[31];
  endfunction

  // expected retire behaviour from the instruction-class rules
  function automatic exp_t model(input logic [31:0] ins,
                                 input logic zz,
                                 input int dw);
    exp_t e;
    int b;
    b = 0;
    for (int k = 0; k < 32; k++)
      if (ins[k]) b = k;
    e.sel = 2'd0;
    e.rf  = 1'b0;
    e.dmc = 0;
    e.dwe = 1'b0;
    e.lat = 4;
    if (b <= 15 || (b >= 17 && b <= 21)
        || (b >= 26 && b <= 28)) begin
      e.rf = 1'b1;
    end else if (b == 16) begin
      e.sel = 2'd3; e.lat = 3;
    end else if (b == 22) begin
      e.rf = 1'b1; e.dmc = dw + 1; e.lat = 5 + dw;
    end else if (b == 23) begin
      e.dwe = 1'b1; e.dmc = dw + 1; e.lat = 4 + dw;
    end else if (b == 24) begin
      e.sel = zz ? 2'd1 : 2'd0; e.lat = 3;
    end else if (b == 25) begin
      e.sel = zz ? 2'd0 : 2'd1; e.lat = 3;
    end else if (b == 29) begin
      e.sel = 2'd2; e.lat = 3;
    end else begin
      e.sel = 2'd2; e.rf = 1'b1;
    end
    return e;
  endfunction

  // driver: sole writer of the bench-side bus signals
  int im_cnt = 0;
  int im_wait = 0;
  int dm_cnt = 0;
  int cur_dw = 0;

  task automatic issue();
    logic [31:0] ins;
    logic zz;
    int dw;
    if (dq_i.size() > 0) begin
      ins = dq_i.pop_front();
      zz  = dq_z.pop_front();
      dw  = dq_w.pop_front();
    end else begin
      ins = 32'd1 << $urandom_range(0, 30);
      zz  = 1'($urandom_range(0, 1));
      dw  = -1;
      rand_left--;
    end
    if (dw < 0) dw = int'($urandom_range(0, dm_wmax));
    bus.i  = ins;
    bus.z  = zz;
    cur_dw = dw;
    if (legal(ins)) begin
      q.push_back(model(ins, zz, dw));
      n_iss++;
    end
    if (!have()) bus.run = 1'b0;
  endtask

  initial begin
    bus.run = 1'b0;
    bus.i = '0;
    bus.z = 1'b0;
    bus.im_ack = 1'b0;
    bus.dm_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bus.im_ack = 1'b0;
        bus.dm_ack = 1'b0;
      end else begin
        if (rand_run && have())
          bus.run = ($urandom_range(0, 7) != 0);
        else if (!rand_run)
          bus.run = have();
        if (bus.im_req) begin
          if (im_cnt >= im_wait && have()) begin
            issue();
            bus.im_ack = 1'b1;
            im_cnt = 0;
            im_wait = int'($urandom_range(0, im_wmax));
          end else begin
            bus.im_ack = 1'b0;
            im_cnt++;
          end
        end else begin
          im_cnt = 0;
          bus.im_ack = spur && ($urandom_range(0, 3) == 0);
        end
        if (bus.dm_req) begin
          bus.dm_ack = (dm_cnt >= cur_dw);
          dm_cnt++;
        end else begin
          dm_cnt = 0;
          bus.dm_ack = spur && ($urandom_range(0, 3) == 0);
        end
      end
    end
  end

  // monitor: per-cycle strobe rules and retire scoreboard
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      dmc = 0;
      chk_idle = 0;
    end else begin
      if (chk_idle) begin
        chk("idle_after_run0",
            {bus.busy, bus.im_req}, 2'b00);
        chk_idle = 0;
      end
      chk("ir_we", bus.ir_we,
          bus.im_req & bus.im_ack);
      if (bus.ir_we) begin
        irwe_cyc = cyc;
        dmc = 0;
      end
      if (bus.dm_req) begin
        dmc++;
        if (q.size() > 0)
          chk("dm_we", bus.dm_we, q[0].dwe);
      end
      if (bus.rf_w && !bus.pc_we)
        chk("rf_w_alone", bus.pc_we, 1'b1);
      if (bus.pc_we) begin
        if (q.size() == 0) begin
          chk("spurious_pc_we", bus.pc_we, 1'b0);
        end else begin
          e = q.pop_front();
          n_ret++;
          chk("pc_sel", bus.pc_sel, e.sel);
          chk("rf_w", bus.rf_w, e.rf);
          chk("dm_req_cycles", dmc, e.dmc);
          chk("latency", cyc - irwe_cyc + 1, e.lat);
          if (!bus.run) chk_idle = 1;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] ins,
                      input logic zz, input int w);
    dq_i.push_back(ins);
    dq_z.push_back(zz);
    dq_w.push_back(w);
  endtask

  task automatic drain(input int budget, input string nm);
    int n;
    n = 0;
    while ((have() || q.size() > 0 || bus.busy)
           && n < budget) begin
      tick();
      n++;
    end
    chk({nm, "_drain"},
        (have() || q.size() > 0 || bus.busy), 1'b0);
  endtask

  task automatic illegal_case(input logic [31:0] ins,
                              input string nm);
    int n;
    push(ins, 1'b0, 0);
    n = 0;
    while (!bus.halted && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_halted"}, bus.halted, 1'b1);
    chk({nm, "_halt_lat"}, cyc - irwe_cyc, 2);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk({nm, "_quiet"},
          {bus.im_req, bus.ir_we, bus.dm_req,
           bus.rf_w, bus.pc_we, bus.halted, bus.busy},
          7'b0000010);
    end
    rst_n = 1'b0;
    #1;
    chk({nm, "_rst"}, {bus.halted, bus.busy}, 2'b00);
    tick();
    rst_n = 1'b1;
  endtask

  logic [31:0] mix_i [14];
  logic        mix_z [14];
  int          mix_w [14];
  int n;

  initial begin
    mix_i = '{32'h1, 32'h1 << 22, 32'h1 << 23,
              32'h1 << 24, 32'h1 << 24,
              32'h1 << 25, 32'h1 << 25,
              32'h1 << 29, 32'h1 << 16,
              32'h1 << 30, 32'h1 << 17,
              32'h1 << 28, 32'h1 << 22,
              32'h1 << 23};
    mix_z = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    mix_w = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 2};

    repeat (3) tick();
    chk("rst_outs",
        {bus.im_req, bus.ir_we, bus.dm_req, bus.dm_we,
         bus.rf_w, bus.pc_we, bus.pc_sel,
         bus.halted, bus.busy}, '0);
    chk("rst_perf", {bus.perf_cyc, bus.perf_ret}, '0);
    rst_n = 1'b1;

    for (int k = 0; k < 10; k++)
      push(32'h1 << (k % 16), 1'b0, 0);
    drain(200, "alu10");
`ifdef MC_SEQ_PERF_EN
    chk("perf_ret", bus.perf_ret, 10);
    chk("perf_cyc", bus.perf_cyc, 40);
`else
    chk("perf_ret", bus.perf_ret, 0);
    chk("perf_cyc", bus.perf_cyc, 0);
`endif

    for (int k = 0; k < 14; k++)
      push(mix_i[k], mix_z[k], mix_w[k]);
    drain(400, "mix");

    illegal_case(32'h0000_0003, "ill_two");
    illegal_case(32'h8000_0000, "ill_b31");

    push(32'h1 << 22, 1'b0, 10);
    n = 0;
    while (!bus.dm_req && n < 20) begin
      tick();
      n++;
    end
    tick();
    chk("mem_req_pre", bus.dm_req, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mem_dm_req", bus.dm_req, 1'b0);
    chk("rst_mem_busy", bus.busy, 1'b0);
    n_iss -= q.size();
    q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_mem_idle", bus.busy, 1'b0);

    spur = 1;
    im_wmax = 3;
    dm_wmax = 4;
    rand_run = 1;
    rand_left = 300;
    drain(20000, "rand");

    chk("retired", n_ret, n_iss);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
